// File: rtl/tpu_bank_req_issuer.sv
// tpu_bank_req_issuer: requestor-side queue in front of one TPU bank arbiter slot.
// Buffers client requests and presents the head entry on the arbiter request lines.
// The head entry is held stable until it is granted.
// A head entry that waits too long without a grant is escalated to priority 2'b11.
// Completion tags and wait statistics are reported.
// Optional build feature: define TPU_BANK_REQ_TIMEOUT_EN to enable the sticky
// timeout_err flag. Without that macro, timeout_err is tied to 0.
//
// Handshake rules:
//   client side : a request transfers on a rising clk edge when in_valid && in_ready.
//                 in_ready depends only on occupancy, never on a same-cycle pop.
//   arbiter side: the head entry is presented while req_valid=1 and is held
//                 unchanged until it is granted. A grant is accepted only when
//                 req_valid && grant.
//                 grant is ignored while req_valid=0.
//
// The FSM state is held in the signal 'state' (IDLE=0, ISSUE=1, AGED=2).
module tpu_bank_req_issuer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int TAG_WIDTH  = 4,
    parameter int AGE_THRESH = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic                         in_write,
    input  logic [1:0]                   in_priority,
    input  logic [TAG_WIDTH-1:0]         in_tag,
    output logic                         req_valid,
    output logic [ADDR_WIDTH-1:0]        req_addr,
    output logic                         req_write,
    output logic [1:0]                   req_priority,
    input  logic                         grant,
    input  logic                         stall,
    output logic                         done_valid,
    output logic [TAG_WIDTH-1:0]         done_tag,
    output logic                         done_write,
    input  logic                         flush,
    input  logic                         clear_counters,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [31:0]                  total_grants,
    output logic [31:0]                  total_wait_cycles,
    output logic [15:0]                  max_wait,
    output logic                         timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        AGED  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] mem_addr  [DEPTH];
    logic                  mem_write [DEPTH];
    logic [1:0]            mem_prio  [DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic [15:0]      wait_cnt;

    logic empty;
    logic push;
    logic pop;

    // stall is informational only; the wait counter already captures ungranted cycles
    logic unused_stall;
    assign unused_stall = &{1'b0, stall};

    assign empty      = (count_q == '0);
    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign fifo_count = count_q;

    // Flush wins over a same-cycle push; a grant with no valid request is ignored
    assign push = in_valid && in_ready && !flush;
    assign pop  = req_valid && grant;

    // Head entry drives the arbiter lines; all zero while the queue is empty
    always_comb begin
        req_valid    = !empty;
        req_addr     = '0;
        req_write    = 1'b0;
        req_priority = 2'b00;
        if (!empty) begin
            req_addr     = mem_addr[rd_ptr];
            req_write    = mem_write[rd_ptr];
            req_priority = (state == AGED) ? 2'b11 : mem_prio[rd_ptr];
        end
    end

    // Queue storage: payload only, no reset needed since occupancy gates its use
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= in_addr;
            mem_write[wr_ptr] <= in_write;
            mem_prio[wr_ptr]  <= in_priority;
            mem_tag[wr_ptr]   <= in_tag;
        end
    end

    // Occupancy after this cycle's push/pop/flush
    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count_q + CNT_W'(1);
                2'b01:   count_next = count_q - CNT_W'(1);
                default: count_next = count_q;
            endcase
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: escalate after AGE_THRESH ungranted cycles, fall back on grant
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count_next != '0) state_next = ISSUE;
            end
            ISSUE: begin
                if (pop)
                    state_next = (count_next != '0) ? ISSUE : IDLE;
                else if (wait_cnt >= 16'(AGE_THRESH - 1))
                    state_next = AGED;
            end
            AGED: begin
                if (pop) state_next = (count_next != '0) ? ISSUE : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Ungranted-cycle counter for the current head entry, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (flush || pop) begin
            wait_cnt <= '0;
        end else if (req_valid && wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Completion pulse one cycle after each grant, flush included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_valid <= 1'b0;
            done_tag   <= '0;
            done_write <= 1'b0;
        end else begin
            done_valid <= pop;
            if (pop) begin
                done_tag   <= mem_tag[rd_ptr];
                done_write <= mem_write[rd_ptr];
            end
        end
    end

    // Statistics; clear takes priority over same-cycle updates, flush has no effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_grants      <= '0;
            total_wait_cycles <= '0;
            max_wait          <= '0;
        end else if (clear_counters) begin
            total_grants      <= '0;
            total_wait_cycles <= '0;
            max_wait          <= '0;
        end else begin
            if (pop) begin
                total_grants <= total_grants + 32'd1;
                if (wait_cnt > max_wait) max_wait <= wait_cnt;
            end
            if (req_valid && !grant) total_wait_cycles <= total_wait_cycles + 32'd1;
        end
    end

`ifdef TPU_BANK_REQ_TIMEOUT_EN
    // Sticky timeout once the head has gone TIMEOUT cycles without a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (clear_counters) begin
            timeout_err <= 1'b0;
        end else if (req_valid && !grant && wait_cnt >= 16'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
        end
    end
`else
    // Timeout detection not built; TIMEOUT kept so both builds share one parameter list
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT < 0);
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: doc/tpu_bank_req_issuer.md
Name: tpu_bank_req_issuer

Overview:
Requestor-side companion to the TPU bank arbiter. It sits between one memory client (DMA, CPU port, systolic feeder or diagnostic port) and one requestor slot of the arbiter. It queues client requests and holds the head request stable on the arbiter request lines until granted. Long-waiting requests are escalated to high priority, and the block reports completion tags and wait statistics.

Parameters:
DEPTH, 4, request FIFO entries; power of 2, at least 2.
ADDR_WIDTH, 16, request address width; must match the arbiter.
TAG_WIDTH, 4, client transaction tag width.
AGE_THRESH, 8, consecutive ungranted cycles before priority escalates to 2'b11; at least 1.
TIMEOUT, 256, ungranted cycles before timeout error; only used when the optional feature is compiled in.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  client request valid
in_ready  out  1  FIFO can accept a request
in_addr  in  ADDR_WIDTH  request address
in_write  in  1  1=write, 0=read
in_priority  in  2  base priority (0=low, 3=high)
in_tag  in  TAG_WIDTH  client tag
req_valid  out  1  to arbiter: request valid
req_addr  out  ADDR_WIDTH  to arbiter: head address
req_write  out  1  to arbiter: head write flag
req_priority  out  2  to arbiter: effective priority
grant  in  1  from arbiter: head granted this cycle
stall  in  1  from arbiter: head stalled this cycle (informational)
done_valid  out  1  one-cycle completion pulse
done_tag  out  TAG_WIDTH  tag of the completed request
done_write  out  1  write flag of the completed request
flush  in  1  synchronous discard of all queued, ungranted requests
clear_counters  in  1  synchronous clear of the statistics counters
fifo_count  out  $clog2(DEPTH+1)  current occupancy
total_grants  out  32  granted requests since reset or clear
total_wait_cycles  out  32  cycles with req_valid=1 and grant=0
max_wait  out  16  longest wait for a single request, sticky
timeout_err  out  1  sticky timeout flag; 0 when the feature is compiled out

Behaviour:
- Reset: FIFO empty, fifo_count=0, in_ready=1, req_valid=0, req_addr/req_write/req_priority=0, done_*=0, all counters 0, wait_cnt=0, FSM in IDLE, timeout_err=0.
- Push and pop:
  - Push when in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH); it does not depend on a same-cycle pop.
  - Pop at the clock edge when req_valid && grant.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Arbiter request lines:
  - req_valid = !empty. req_addr, req_write and the base priority come combinationally from the head entry.
  - The head entry stays stable until granted.
  - A newly pushed entry becomes visible on the request lines the cycle after the push (no bypass).
  - grant is ignored while req_valid=0.
- FSM:
  - IDLE (empty): goes to ISSUE when the FIFO becomes non-empty.
  - ISSUE: req_priority = head base priority. wait_cnt increments on each ungranted cycle. Goes to AGED when wait_cnt reaches AGE_THRESH-1 and the head is still ungranted that cycle.
  - AGED: req_priority = 2'b11.
  - On grant from ISSUE or AGED: wait_cnt returns to 0. The next state is ISSUE if entries remain after the pop, otherwise IDLE.
  - wait_cnt saturates at 16'hFFFF.
- Completion:
  - The cycle after a grant: done_valid=1, with done_tag and done_write taken from the granted entry.
  - done_valid=0 otherwise.
  - Back-to-back grants produce back-to-back done pulses.
- Flush:
  - Next cycle: FIFO empty, wait_cnt=0, FSM in IDLE.
  - Flush and grant in the same cycle: the access has occurred, so done_valid still pulses for the granted entry. All other entries are dropped.
  - Flush and push in the same cycle: flush wins and the pushed entry is discarded.
  - Counters are unaffected by flush.
- Counters:
  - total_grants increments on each grant.
  - total_wait_cycles increments on each cycle with req_valid && !grant.
  - On grant, max_wait updates to wait_cnt if wait_cnt > max_wait.
  - 32-bit counters wrap.
  - clear_counters zeroes total_grants, total_wait_cycles and max_wait, and takes priority over same-cycle increments. It also clears timeout_err.
- Reset mid-operation: all state returns to reset values immediately. Queued requests are lost and no done pulse is generated.

Optional Feature:
- Macro: TPU_BANK_REQ_TIMEOUT_EN.
- Defined: when wait_cnt reaches TIMEOUT while ungranted, timeout_err goes to 1. It is sticky until clear_counters or reset. The request stays queued and continues to issue.
- Undefined: no timeout logic; timeout_err is tied to 0.

Test Plan:
- Single request: push addr=16'h0013, tag=5, write=1, priority=1; grant in the first cycle req_valid=1 → done_valid one cycle later with tag=5 and done_write=1; total_grants=1, total_wait_cycles=0.
- Fill and wrap (DEPTH=4): push 4 entries → in_ready=0 and fifo_count=4. Then grant every cycle while pushing 4 more → done tags come out strictly in FIFO order 0..7, with one pulse per grant.
- Aging: push priority=0, hold grant=0 and stall=1 for 10 cycles → req_priority=0 for cycles 1-8 and 2'b11 from cycle 9. A grant in cycle 11 → total_wait_cycles=10, max_wait=10, FSM back to IDLE.
- Flush with grant: 3 entries queued; assert flush and grant in the same cycle → one done pulse with the head tag; next cycle fifo_count=0 and req_valid=0.
- Counter clear: build up counts, then assert clear_counters in the same cycle as a grant → all three counters read 0 the next cycle.
- Timeout (macro defined, TIMEOUT=16): hold grant=0 for 16 cycles → timeout_err=1 and the request is still presented. With the macro undefined, the same stimulus gives timeout_err=0.
